uart_rx_loader: RTL and testbench

//  AXI4-Lite master that drives the AXI UART Lite slave inside top. It is the stage directly upstream of the slave port.

---
 rtl/uart_loader_pkg.sv | 26 ++
 rtl/uart_rx_loader.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_loader.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared constants and state type for the UART Lite byte loader.
// UART Lite register map, status/control bit values and the loader FSM states.
package uart_loader_pkg;

  localparam logic [3:0] RX_FIFO = 4'h0;
  localparam logic [3:0] TX_FIFO = 4'h4;
  localparam logic [3:0] STAT    = 4'h8;
  localparam logic [3:0] CTRL    = 4'hC;

  localparam int         RX_VALID  = 0;
  localparam logic [7:0] RST_FIFOS = 8'h03;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [3:0] {
    IDLE,
    CFG_W,
    CFG_B,
    POLL_AR,
    POLL_R,
    DATA_AR,
    DATA_R,
    MEM_WR,
    DONE
  } state_t;

endpackage

// File: rtl/uart_rx_loader.sv
// AXI4-Lite master that resets a UART Lite, drains its RX FIFO and packs byte
// pairs little-endian into sequential memory words until LOAD_WORDS are written.
module uart_rx_loader
  import uart_loader_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int MEMORY_ADDR_WIDTH  = 18,
  parameter int MEMORY_DATA_WIDTH  = 16,
  parameter int LOAD_WORDS         = 262144
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              UART_initialize,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY,
  output logic [MEMORY_ADDR_WIDTH-1:0]      mem_addr,
  output logic [MEMORY_DATA_WIDTH-1:0]      mem_wdata,
  output logic                              mem_we,
  output logic                              load_done,
  output logic                              axi_err
);

  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam int MAW = MEMORY_ADDR_WIDTH;

  // One extra count bit so that LOAD_WORDS == 2**MAW is reachable.
  localparam logic [MAW:0] LOAD_CNT = (MAW+1)'(LOAD_WORDS);

  state_t       state;
  logic [MAW:0] count;
  logic [7:0]   low_byte;
  logic         phase;
  logic         r_ok;
  logic         b_ok;
  logic [7:0]   rx_byte;
  logic         unused_rdata;

  assign r_ok         = (M_AXI_RRESP == RESP_OKAY);
  assign b_ok         = (M_AXI_BRESP == RESP_OKAY);
  assign rx_byte      = M_AXI_RDATA[7:0];
  assign unused_rdata = ^M_AXI_RDATA[DW-1:8];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      count         <= '0;
      low_byte      <= '0;
      phase         <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      load_done     <= 1'b0;
      axi_err       <= 1'b0;
    end else begin
      M_AXI_WSTRB <= '1;
      case (state)
        IDLE: begin
          if (UART_initialize) begin
            M_AXI_AWADDR  <= AW'(CTRL);
            M_AXI_WDATA   <= DW'(RST_FIFOS);
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= CFG_W;
          end
        end
        CFG_W: begin
          // Each channel retires on its own handshake; advance once both have.
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= CFG_B;
          end
        end
        CFG_B: begin
          if (M_AXI_BVALID) begin
            if (!b_ok) axi_err <= 1'b1;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= AW'(STAT);
            M_AXI_ARVALID <= 1'b1;
            state         <= POLL_AR;
          end
        end
        POLL_AR, DATA_AR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= (state == POLL_AR) ? POLL_R : DATA_R;
          end
        end
        POLL_R: begin
          if (M_AXI_RVALID) begin
            if (!r_ok) axi_err <= 1'b1;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b1;
            if (r_ok && M_AXI_RDATA[RX_VALID]) begin
              M_AXI_ARADDR <= AW'(RX_FIFO);
              state        <= DATA_AR;
            end else begin
              M_AXI_ARADDR <= AW'(STAT);
              state        <= POLL_AR;
            end
          end
        end
        DATA_R: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            if (!r_ok) begin
              axi_err       <= 1'b1;
              M_AXI_ARADDR  <= AW'(STAT);
              M_AXI_ARVALID <= 1'b1;
              state         <= POLL_AR;
            end else if (!phase) begin
              low_byte      <= rx_byte;
              phase         <= 1'b1;
              M_AXI_ARADDR  <= AW'(STAT);
              M_AXI_ARVALID <= 1'b1;
              state         <= POLL_AR;
            end else begin
              mem_wdata <= {rx_byte, low_byte};
              mem_we    <= 1'b1;
              phase     <= 1'b0;
              state     <= MEM_WR;
            end
          end
        end
        MEM_WR: begin
          mem_we   <= 1'b0;
          mem_addr <= mem_addr + MAW'(1);
          count    <= count + (MAW+1)'(1);
          if (count + (MAW+1)'(1) == LOAD_CNT) begin
            load_done <= 1'b1;
            state     <= DONE;
          end else begin
            M_AXI_ARADDR  <= AW'(STAT);
            M_AXI_ARVALID <= 1'b1;
            state         <= POLL_AR;
          end
        end
        DONE: begin
          if (UART_initialize) begin
            mem_addr      <= '0;
            count         <= '0;
            phase         <= 1'b0;
            load_done     <= 1'b0;
            M_AXI_AWADDR  <= AW'(CTRL);
            M_AXI_WDATA   <= DW'(RST_FIFOS);
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= CFG_W;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed/randomized bench for uart_rx_loader against a behavioural UART Lite
// slave; expected memory words are built from the byte stream the bench feeds.
module tb_uart_rx_loader;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int MAW = 1;
  localparam int MDW = 16;
  localparam int LW  = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic init = 1'b0;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp = 0, rresp = 0;
  logic [DW-1:0] rdata = 0;
  logic [MAW-1:0] mem_addr;
  logic [MDW-1:0] mem_wdata;
  logic mem_we, load_done, axi_err;

  always #5 clk = ~clk;

  uart_rx_loader #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
    .MEMORY_ADDR_WIDTH(MAW), .MEMORY_DATA_WIDTH(MDW), .LOAD_WORDS(LW)
  ) dut (
    .clk(clk), .resetn(resetn), .UART_initialize(init),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .load_done(load_done), .axi_err(axi_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // slave configuration and UART contents
  int aw_delay = 0, w_delay = 0, ar_delay = 0, stat_hold = 0;
  logic [7:0] rx_q[$];
  bit         rx_err_q[$];

  // observed traffic
  logic [AW-1:0]   aw_log[$];
  logic [DW-1:0]   w_log[$];
  logic [DW/8-1:0] wstrb_log[$];
  logic [AW-1:0]   ar_log[$];
  logic [MAW+MDW-1:0] mem_log[$];
  int b_cnt = 0;
  int proto_err = 0;

  // slave internal state
  int aw_cnt, w_cnt, ar_cnt, we_run;
  bit aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_got, w_got, r_pend;
  bit aw_hold, w_hold, ar_hold;
  logic [AW-1:0] aw_prev, ar_prev;
  logic [DW-1:0] w_prev;
  logic [DW/8-1:0] wstrb_prev;

  task automatic slave_clear();
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; we_run = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
    aw_got = 0; w_got = 0; r_pend = 0;
    aw_hold = 0; w_hold = 0; ar_hold = 0;
  endtask

  // Behavioural UART Lite slave; every decision is made on the falling edge.
  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (!resetn) begin
        slave_clear();
      end else begin
        if (aw_hold && (!awvalid || awaddr !== aw_prev)) proto_err++;
        if (w_hold && (!wvalid || wdata !== w_prev)) proto_err++;
        if (ar_hold && (!arvalid || araddr !== ar_prev)) proto_err++;
        if (mem_we) begin
          mem_log.push_back({mem_addr, mem_wdata});
          we_run++;
          if (we_run > 1) proto_err++;
        end else we_run = 0;

        if (aw_hs) begin aw_log.push_back(aw_prev); awready = 0; aw_cnt = 0; aw_got = 1; end
        if (w_hs) begin
          w_log.push_back(w_prev); wstrb_log.push_back(wstrb_prev);
          wready = 0; w_cnt = 0; w_got = 1;
        end
        if (b_hs) begin bvalid = 0; b_cnt++; end
        if (ar_hs) begin ar_log.push_back(ar_prev); arready = 0; ar_cnt = 0; r_pend = 1; end
        if (r_hs) rvalid = 0;
        if ((arvalid && (ar_hs || r_pend || rvalid)) || (awvalid && arvalid)) proto_err++;

        if (awvalid && !awready) begin if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++; end
        if (wvalid && !wready) begin if (w_cnt >= w_delay) wready = 1; else w_cnt++; end
        if (arvalid && !arready && !r_pend) begin if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++; end
        if (aw_got && w_got && !bvalid) begin bvalid = 1; bresp = 2'b00; aw_got = 0; w_got = 0; end
        if (r_pend && !rvalid) begin
          r_pend = 0; rvalid = 1; rresp = 2'b00; rdata = '0;
          if (ar_log[ar_log.size()-1] == 4'h8) begin
            if (stat_hold > 0) stat_hold--;
            else rdata = (rx_q.size() > 0) ? 32'h1 : 32'h0;
          end else if (rx_q.size() > 0) begin
            rdata = {24'($urandom), rx_q.pop_front()};
            if (rx_err_q.pop_front()) rresp = 2'b10;
          end
        end

        aw_hs = awvalid && awready; aw_hold = awvalid && !aw_hs; aw_prev = awaddr;
        w_hs = wvalid && wready; w_hold = wvalid && !w_hs; w_prev = wdata; wstrb_prev = wstrb;
        ar_hs = arvalid && arready; ar_hold = arvalid && !ar_hs; ar_prev = araddr;
        b_hs = bvalid && bready;
        r_hs = rvalid && rready;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_init();
    @(negedge clk); init = 1;
    @(negedge clk); init = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_mem(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_log.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (load_done) begin ok = 1; break; end
    end
  endtask

  // Feed n good bytes; record them as the reference byte stream for this load.
  task automatic feed(input int n, inout logic [7:0] good[$]);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_q.push_back(b); rx_err_q.push_back(1'b0); good.push_back(b);
    end
  endtask

  // Reference: word k of a load holds good bytes 2k (low) and 2k+1 (high) at address k mod 2**MAW.
  function automatic logic [MAW+MDW-1:0] ref_word(input int k, input logic [7:0] good[$]);
    return {MAW'(k % (1 << MAW)), good[2*k+1], good[2*k]};
  endfunction

  initial begin
    bit ok;
    int base, first_rx, naw;
    logic [7:0] good[$];

    // reset
    #12;
    check("reset_outputs", {awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid,
                            rready, mem_addr, mem_wdata, mem_we, load_done, axi_err}, '0);
    @(negedge clk); resetn = 1;
    cycles(3);
    check("idle_no_activity", {awvalid, wvalid, arvalid, load_done}, '0);

    // first load word from a delayed RX FIFO
    stat_hold = 3;
    rx_q.push_back(8'h34); rx_err_q.push_back(0);
    rx_q.push_back(8'h12); rx_err_q.push_back(0);
    pulse_init();
    wait_mem(1, 400, ok);
    check("first_word_timeout", ok, 1);
    check("cfg_aw_count", aw_log.size(), 1);
    check("cfg_awaddr", aw_log[0], 4'hC);
    check("cfg_wdata", w_log[0], 32'h3);
    check("cfg_wstrb", wstrb_log[0], 4'hF);
    check("cfg_b_count", b_cnt, 1);
    check("first_araddr", ar_log[0], 4'h8);
    first_rx = -1;
    foreach (ar_log[i]) if (first_rx < 0 && ar_log[i] == 4'h0) first_rx = i;
    check("stat_polls_before_rx", first_rx, 4);
    check("word0", mem_log[0], {1'b0, 16'h1234});
    cycles(20);
    pulse_init();
    cycles(20);
    check("single_mem_we", mem_log.size(), 1);
    check("init_ignored_busy", aw_log.size(), 1);
    check("no_err_yet", axi_err, 0);

    // error response drops a byte; next good pair still lands at address 1
    rx_q.push_back(8'hEE); rx_err_q.push_back(1);
    good.delete();
    feed(2, good);
    wait_mem(2, 400, ok);
    check("err_word_timeout", ok, 1);
    check("axi_err_set", axi_err, 1);
    check("word_after_err", mem_log[1], {1'b1, good[1], good[0]});
    wait_done(50, ok);
    check("done_after_two", ok, 1);
    check("mem_addr_wrap", mem_addr, 0);

    // slave stalls: AWREADY well before WREADY, slow ARREADY
    aw_delay = 1; w_delay = 4; ar_delay = 5;
    good.delete();
    feed(4, good);
    base = mem_log.size();
    pulse_init();
    wait_done(3000, ok);
    check("stall_done", ok, 1);
    check("stall_aw_count", aw_log.size(), 2);
    check("stall_w_count", w_log.size(), 2);
    check("stall_b_count", b_cnt, 2);
    check("stall_word0", mem_log[base], ref_word(0, good));
    check("stall_word1", mem_log[base+1], ref_word(1, good));
    check("axi_err_sticky", axi_err, 1);

    // full loads with extra bytes left behind; various AW/W orderings
    for (int it = 0; it < 4; it++) begin
      aw_delay = (it == 0) ? 2 : (it == 1) ? 4 : $urandom_range(0, 3);
      w_delay  = (it == 0) ? 2 : (it == 1) ? 0 : $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3);
      good.delete();
      feed(6, good);
      base = mem_log.size();
      naw = aw_log.size();
      pulse_init();
      wait_done(3000, ok);
      check("load_done", ok, 1);
      check("load_cfg_once", aw_log.size(), naw + 1);
      check("load_word0", mem_log[base], ref_word(0, good));
      check("load_word1", mem_log[base+1], ref_word(1, good));
      cycles(30);
      check("no_extra_writes", mem_log.size(), base + 2);
      check("bytes_left_unread", rx_q.size(), 2);
      check("done_held", load_done, 1);
      rx_q.delete(); rx_err_q.delete();
    end

    // reset during an outstanding read address
    aw_delay = 0; w_delay = 0; ar_delay = 8;
    pulse_init();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arvalid) begin ok = 1; break; end
    end
    check("arvalid_seen", ok, 1);
    #2 resetn = 0;
    #1;
    check("reset_mid_txn", {awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid,
                            rready, mem_addr, mem_wdata, mem_we, load_done, axi_err}, '0);
    cycles(2);
    @(negedge clk); resetn = 1;
    ar_delay = 0;
    naw = aw_log.size();
    cycles(10);
    check("idle_after_reset", {awvalid, wvalid, arvalid, rready, bready, load_done, axi_err}, '0);
    check("no_cfg_without_init", aw_log.size(), naw);
    pulse_init();
    cycles(30);
    check("cfg_after_reset", aw_log.size(), naw + 1);
    check("protocol_clean", proto_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
